// File: rtl/shared_mul_pkg.sv
// shared_mul_pkg: shared types and constants for shared_mul_sequencer; SHARED_MUL_HI_EN widens the accumulator to 64 bits
package shared_mul_pkg;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int SMUL_LAT_LO = 5;
  localparam int SMUL_LAT_HI = 6;
`ifdef SHARED_MUL_HI_EN
  localparam int ACC_W = 64;
`else
  localparam int ACC_W = 32;
`endif
  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL0,
    S_MUL1,
    S_MUL2,
    S_MUL3,
    S_DRAIN,
    S_RESP
  } smul_state_e;
endpackage

// File: rtl/mul16_cell.sv
// mul16_cell: registered 16x16 unsigned multiply, 1-cycle latency; ports clk, reset (sync clear), en_i, a_i, b_i, p_o
module mul16_cell
  import shared_mul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [HALF_W-1:0] a_i,
  input  logic [HALF_W-1:0] b_i,
  output logic [WORD_W-1:0] p_o
);
  logic [WORD_W-1:0] p_q;
  always_ff @(posedge clk) begin
    if (reset) p_q <= '0;
    else if (en_i) p_q <= WORD_W'(a_i) * WORD_W'(b_i);
  end
  assign p_o = p_q;
endmodule

// File: rtl/shared_mul_sequencer.sv
// shared_mul_sequencer: round-robin shared 32x32 multiplier built from one 16x16 cell
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_a/req_b per requester;
// rsp_valid/rsp_ready/rsp_id/rsp_lo (+rsp_hi with SHARED_MUL_HI_EN); busy.
// SHARED_MUL_HI_EN adds the fourth partial product and the high product word.
module shared_mul_sequencer
  import shared_mul_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*WORD_W-1:0] req_a,
  input  logic [NUM_REQ*WORD_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [WORD_W-1:0]         rsp_lo,
`ifdef SHARED_MUL_HI_EN
  output logic [WORD_W-1:0]         rsp_hi,
`endif
  output logic                      busy
);
  smul_state_e       state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_id;
  logic [ID_W:0]     cand;
  logic              gnt_found;
  logic [WORD_W-1:0] a_q, a_d, b_q, b_d, a_sel, b_sel;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              cell_en;
  logic [HALF_W-1:0] cell_a, cell_b;
  logic [WORD_W-1:0] cell_p;
  // first valid requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    gnt_found = 1'b0;
    gnt_id = '0;
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      cand = (cand >= (ID_W+1)'(NUM_REQ)) ? cand - (ID_W+1)'(NUM_REQ) : cand;
      if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id = cand[ID_W-1:0];
      end
    end
  end
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        a_sel = req_a[i*WORD_W +: WORD_W];
        b_sel = req_b[i*WORD_W +: WORD_W];
      end
    end
  end
  assign cell_en = (state_q == S_MUL0) || (state_q == S_MUL1) || (state_q == S_MUL2) ||
                   (state_q == S_MUL3) || (state_q == S_DRAIN);
  assign cell_a = (state_q == S_MUL2 || state_q == S_MUL3) ? a_q[WORD_W-1:HALF_W] : a_q[HALF_W-1:0];
  assign cell_b = (state_q == S_MUL1 || state_q == S_MUL3) ? b_q[WORD_W-1:HALF_W] : b_q[HALF_W-1:0];
  mul16_cell u_cell (
    .clk  (clk),
    .reset(reset),
    .en_i (cell_en),
    .a_i  (cell_a),
    .b_i  (cell_b),
    .p_o  (cell_p)
  );
  // each state accumulates the product issued one state earlier
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready = NUM_REQ'(1) << gnt_id;
          id_d = gnt_id;
          a_d = a_sel;
          b_d = b_sel;
          rr_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
          state_d = S_MUL0;
        end
      end
      S_MUL0: state_d = S_MUL1;
      S_MUL1: begin
        acc_d = ACC_W'(cell_p);
        state_d = S_MUL2;
      end
`ifdef SHARED_MUL_HI_EN
      S_MUL2: begin
        acc_d = acc_q + (ACC_W'(cell_p) << HALF_W);
        state_d = S_MUL3;
      end
      S_MUL3: begin
        acc_d = acc_q + (ACC_W'(cell_p) << HALF_W);
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        acc_d = acc_q + (ACC_W'(cell_p) << WORD_W);
        state_d = S_RESP;
      end
`else
      S_MUL2: begin
        acc_d = acc_q + (ACC_W'(cell_p) << HALF_W);
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        acc_d = acc_q + (ACC_W'(cell_p) << HALF_W);
        state_d = S_RESP;
      end
`endif
      S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
    end
  end
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id = id_q;
  assign rsp_lo = acc_q[WORD_W-1:0];
`ifdef SHARED_MUL_HI_EN
  assign rsp_hi = acc_q[ACC_W-1:WORD_W];
`endif
  assign busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_shared_mul_sequencer.sv
// tb_shared_mul_sequencer: directed self-checking bench for shared_mul_sequencer with NUM_REQ=4
module tb_shared_mul_sequencer;
`ifdef SHARED_MUL_HI_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_lo;
`ifdef SHARED_MUL_HI_EN
  logic [31:0]  rsp_hi;
`endif
  logic         busy;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] rr_lo [4] = '{32'h00010000, 32'h00020002, 32'h00030006, 32'h0004000C};
  shared_mul_sequencer #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_lo   (rsp_lo),
`ifdef SHARED_MUL_HI_EN
    .rsp_hi   (rsp_hi),
`endif
    .busy     (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input string tag, input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] valid, input logic [3:0] valid_after, input logic [3:0] exp_gnt);
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_valid = valid;
    #1 chk({tag, "_grant"}, req_ready, exp_gnt);
    @(posedge clk);
    @(negedge clk);
    req_valid = valid_after;
    chk({tag, "_pulse"}, req_ready, 4'b0000);
    chk({tag, "_busy"}, busy, 1'b1);
    repeat (LAT-2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_early"}, rsp_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check_rsp(input string tag, input logic [1:0] id, input logic [31:0] lo, input logic [31:0] hi);
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_lo"}, rsp_lo, lo);
`ifdef SHARED_MUL_HI_EN
    chk({tag, "_hi"}, rsp_hi, hi);
`else
    if (hi != hi) $display("unreachable");
`endif
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_id", rsp_id, 2'd0);
    chk("rst_lo", rsp_lo, 32'd0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    start("t1", 0, 32'h00010003, 32'h00020004, 4'b0001, 4'b0000, 4'b0001);
    check_rsp("t1", 2'd0, 32'h000A000C, 32'h00000002);
    @(posedge clk);
    @(negedge clk);
    chk("t1_one_cycle", rsp_valid, 1'b0);
    chk("t1_idle", busy, 1'b0);
    start("t2", 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0100, 4'b0000, 4'b0100);
    check_rsp("t2", 2'd2, 32'h00000001, 32'hFFFFFFFE);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_a[31:0] = 32'd7;
    req_b[31:0] = 32'd6;
    start("t3", 3, 32'h12345678, 32'h00000009, 4'b1001, 4'b0001, 4'b1000);
    for (int k = 0; k < 10; k++) begin
      check_rsp("t3_stall", 2'd3, 32'hA3D70A38, 32'h0);
      chk("t3_no_grant", req_ready, 4'b0000);
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check_rsp("t3_hs", 2'd3, 32'hA3D70A38, 32'h0);
    chk("t3_hs_no_grant", req_ready, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    start("t4", 0, 32'd7, 32'd6, 4'b0001, 4'b0000, 4'b0001);
    check_rsp("t4", 2'd0, 32'd42, 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_a[63:32] = 32'd5;
    req_b[63:32] = 32'd5;
    req_valid = 4'b0010;
    #1 chk("t5_grant", req_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    chk("t5_mul1_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_valid", rsp_valid, 1'b0);
    chk("t5_rst_lo", rsp_lo, 32'd0);
    chk("t5_rst_id", rsp_id, 2'd0);
    chk("t5_rst_ready", req_ready, 4'b0000);
    reset = 1'b0;
    repeat (LAT+1) @(posedge clk);
    @(negedge clk);
    chk("t5_no_rsp", rsp_valid, 1'b0);
    chk("t5_no_busy", busy, 1'b0);
    start("t6", 1, 32'h00010003, 32'h00020004, 4'b0010, 4'b0000, 4'b0010);
    check_rsp("t6", 2'd1, 32'h000A000C, 32'h00000002);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      start("rr", k % 4, 32'(k % 4 + 1), 32'h00010000 + 32'(k % 4), 4'b1111, 4'b1111, 4'(1 << (k % 4)));
      check_rsp("rr", 2'(k % 4), rr_lo[k % 4], 32'd0);
      chk("rr_resp_ready", req_ready, 4'b0000);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 4'b0000;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
